// File: rtl/deserializer_rst.sv
// Serial-to-parallel converter, LSB first, with a one-entry output register.
// Dropped words set o_overrun; a partial word abandoned by i_valid sets o_frame_err.
module deserializer_rst #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic                  i_data,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_busy,
    output logic                  o_overrun,
    output logic                  o_frame_err
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    localparam int                CNT_W     = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  MAX_VALUE = CNT_W'(DATA_WIDTH - 1);

    state_t                  state_reg     = IDLE;
    state_t                  state_next;
    logic [CNT_W-1:0]        count_reg     = '0;
    logic [CNT_W-1:0]        count_next;
    logic [DATA_WIDTH-1:0]   shift_reg     = '0;
    logic [DATA_WIDTH-1:0]   shift_next;
    logic [DATA_WIDTH-1:0]   data_reg      = '0;
    logic [DATA_WIDTH-1:0]   data_next;
    logic                    valid_reg     = 1'b0;
    logic                    valid_next;
    logic                    overrun_reg   = 1'b0;
    logic                    overrun_next;
    logic                    frame_err_reg = 1'b0;
    logic                    frame_err_next;
    logic                    word_done;
    logic                    xfer;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            shift_reg     <= '0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            shift_reg     <= shift_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            overrun_reg   <= overrun_next;
            frame_err_reg <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        shift_next     = shift_reg;
        data_next      = data_reg;
        valid_next     = valid_reg;
        overrun_next   = overrun_reg;
        frame_err_next = frame_err_reg;
        word_done      = 1'b0;
        xfer           = valid_reg & i_ready;

        if (i_valid) begin
            // count is 0 in IDLE, so the same indexed write serves both states
            shift_next[count_reg] = i_data;
            if (count_reg == MAX_VALUE) begin
                count_next = '0;
                state_next = IDLE;
                word_done  = 1'b1;
            end else begin
                count_next = count_reg + CNT_W'(1);
                state_next = SHIFT;
            end
        end else if (state_reg == SHIFT) begin
            count_next     = '0;
            state_next     = IDLE;
            shift_next     = '0;
            frame_err_next = 1'b1;
        end

        // A completing word may reuse the slot being drained on this edge
        if (word_done) begin
            if (valid_reg && !i_ready) begin
                overrun_next = 1'b1;
            end else begin
                data_next  = shift_next;
                valid_next = 1'b1;
            end
        end else if (xfer) begin
            valid_next = 1'b0;
        end
    end

    assign o_data      = data_reg;
    assign o_valid     = valid_reg;
    assign o_busy      = (count_reg != '0);
    assign o_overrun   = overrun_reg;
    assign o_frame_err = frame_err_reg;

`ifdef FORMAL
    logic past_valid = 1'b0;
    always_ff @(posedge i_clk) past_valid <= 1'b1;

    always_ff @(posedge i_clk) begin
        assert (count_reg <= MAX_VALUE);
        if (past_valid && $past(i_rst)) begin
            assert (count_reg == '0 && state_reg == IDLE && !valid_reg
                    && !overrun_reg && !frame_err_reg);
        end
        if (past_valid && !$past(i_rst) && $past(valid_reg && !i_ready)) begin
            assert (valid_reg && data_reg == $past(data_reg));
        end
        if (past_valid && !$past(i_rst) && $past(word_done && valid_reg && !i_ready)) begin
            assert (overrun_reg && data_reg == $past(data_reg));
        end
        if (past_valid && !$past(i_rst) && $past(word_done && valid_reg && i_ready)) begin
            assert (valid_reg && data_reg == $past(shift_next)
                    && overrun_reg == $past(overrun_reg));
        end
        if (past_valid) begin
            cover (!$past(i_rst) && $past(xfer) && xfer);
        end
    end
`endif

endmodule
